instr_mem_responder: RTL and testbench

Instruction-memory responder that serves the core's fetch interface: accepts one fetch request at a time, waits a configurable latency, then returns the addressed word under a valid/ready handshake. It sits between the core's fetch stage and the program storage. A side load port lets the testbench preload or patch program words before or during execution.

---
 rtl/instr_mem_responder.sv | 130 +++++++++++++
 tb/tb_instr_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fixed-latency instruction fetch responder with side load port
// Optional feature macro: RESP_PARITY_EN adds resp_parity (even parity over resp_data).
module instr_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_ext,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
`ifdef RESP_PARITY_EN
  ,
  output logic              resp_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              capture;
  logic              handshake;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_in_range;
  logic [DATA_W-1:0] cap_word;
  logic              load_in_range;

  assign accept        = (state == IDLE) && req_valid;
  assign capture       = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 2'd0));
  assign handshake     = (state == RESP) && resp_ready;
  // With LATENCY=1 the capture happens on the accept edge, before addr_q holds the address.
  assign cap_addr      = (state == IDLE) ? req_addr : addr_q;
  assign cap_in_range  = 32'(cap_addr) < 32'(DEPTH);
  assign cap_word      = cap_in_range ? mem[cap_addr] : '0;
  assign load_in_range = 32'(load_addr) < 32'(DEPTH);

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 2'd0) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Program storage is never reset so preloaded code survives a core reset.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      addr_q    <= '0;
      cnt       <= 2'd0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end
      if (capture) begin
        resp_data <= cap_word;
        resp_err  <= !cap_in_range;
      end else if (handshake) begin
        resp_err  <= 1'b0;
      end
    end
  end

`ifdef RESP_PARITY_EN
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      resp_parity <= 1'b0;
    end else if (capture) begin
      resp_parity <= ^cap_word;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed bench with a cycle-level reference model for instr_mem_responder
module tb_instr_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 200;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_ext = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              busy;
`ifdef RESP_PARITY_EN
  logic              resp_parity;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst_ext   (rst_ext),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
`ifdef RESP_PARITY_EN
    , .resp_parity(resp_parity)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a fetch accepted on edge c is answered on edge c+LAT from the
  // memory image as it stood before that edge's load; handshake returns to idle.
  logic [DATA_W-1:0] m_mem [256];
  bit                m_busy = 1'b0;
  bit                m_pend = 1'b0;
  bit                m_err  = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_cyc  = 0;
  int                m_due  = 0;

  always @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_data = '0;
    end else begin
      m_cyc++;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1;
          m_addr = req_addr;
          m_due  = m_cyc + LAT;
        end
      end else if (!m_pend) begin
        if (m_cyc == m_due) begin
          m_pend = 1'b1;
          m_err  = (int'(m_addr) >= DEPTH);
          m_data = m_err ? '0 : m_mem[m_addr];
        end
      end else if (resp_ready) begin
        m_busy = 1'b0;
        m_pend = 1'b0;
        m_err  = 1'b0;
      end
      if (load_en && int'(load_addr) < DEPTH) m_mem[load_addr] = load_data;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_req_ready", req_ready, !m_busy);
      check("m_busy", busy, m_busy);
      check("m_resp_valid", resp_valid, m_pend);
      check("m_resp_err", resp_err, m_err);
      if (m_pend) begin
        check("m_resp_data", resp_data, m_data);
`ifdef RESP_PARITY_EN
        check("m_resp_parity", resp_parity, ^m_data);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input int hold,
                       input logic [DATA_W-1:0] ed, input logic ee, input string nm);
    req_valid = 1'b1; req_addr = a; resp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    check({nm, "_busy"}, busy, 1);
    check({nm, "_ready_lo"}, req_ready, 0);
    step();
    check({nm, "_not_yet"}, resp_valid, 0);
    step();
    check({nm, "_valid"}, resp_valid, 1);
    check({nm, "_data"}, resp_data, ed);
    check({nm, "_err"}, resp_err, ee);
    for (int k = 0; k < hold; k++) begin
      step();
      check({nm, "_held_valid"}, resp_valid, 1);
      check({nm, "_held_data"}, resp_data, ed);
      check({nm, "_held_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({nm, "_done_valid"}, resp_valid, 0);
    check({nm, "_done_ready"}, req_ready, 1);
    check({nm, "_done_err"}, resp_err, 0);
  endtask

  initial begin
    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    rst_ext = 1'b0;
    chk_on  = 1'b1;

    do_load(8'h05, 16'hA55A);
    do_load(8'h00, 16'h0F0F);
    do_load(8'h20, 16'h0007);
    do_load(8'h10, 16'h1111);
    do_load(8'hC8, 16'hDEAD);
    do_load(8'hC7, 16'h3C3C);

    fetch(8'h05, 0, 16'hA55A, 1'b0, "lat2");
    fetch(8'h05, 4, 16'hA55A, 1'b0, "hold4");
    fetch(8'hC8, 0, 16'h0000, 1'b1, "oor");
    fetch(8'h00, 0, 16'h0F0F, 1'b0, "after_oor");
    fetch(8'hC7, 0, 16'h3C3C, 1'b0, "last_word");

    // Load one cycle before capture is seen; load on the capture edge is not.
    req_valid = 1'b1; req_addr = 8'h10; resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'h1234;
    step();
    load_data = 16'hBEEF;
    step();
    load_en = 1'b0;
    check("wait_load_valid", resp_valid, 1);
    check("wait_load_data", resp_data, 16'h1234);
    step();
    resp_ready = 1'b0;
    check("wait_load_done", resp_valid, 0);
    fetch(8'h10, 0, 16'hBEEF, 1'b0, "same_edge_landed");

    fetch(8'h20, 0, 16'h0007, 1'b0, "par7");
`ifdef RESP_PARITY_EN
    req_valid = 1'b1; req_addr = 8'h20; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("parity_0007", resp_parity, 1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
`endif

    // Request held high continuously: model checks no overlap at handshake.
    req_valid = 1'b1; req_addr = 8'h05; resp_ready = 1'b1;
    repeat (9) step();
    req_valid = 1'b0;
    repeat (4) step();
    resp_ready = 1'b0;
    check("b2b_idle", busy, 0);

    // Reset mid-WAIT discards the fetch.
    req_valid = 1'b1; req_addr = 8'h05;
    step();
    req_valid = 1'b0;
    check("midrst_busy_before", busy, 1);
    rst_ext = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_ready", req_ready, 1);
    step();
    step();
    rst_ext = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("postrst_no_resp", resp_valid, 0);
      check("postrst_idle", busy, 0);
    end
    resp_ready = 1'b0;
    fetch(8'h00, 0, 16'h0F0F, 1'b0, "post_reset_fetch");

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
